shifter_scan_ctrl: RTL
======================

Name: shifter_scan_ctrl

Overview:
- Round-robin scheduler that shares the 4-way output shifter (8-bit value plus 2-bit lane select) among four requesters.
- Each granted requester gets its 8-bit value driven onto the selected lane for a fixed dwell time, then receives a one-cycle done pulse.
- Sits directly upstream of the shifter. Its sel/cnt outputs feed the shifter's s/cnt inputs.

Parameters:
- DWELL, 4, number of cycles a grant holds the shared path; legal 1..255.
- DW, 8, data width of each requester value and of cnt.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous active-high reset
- req  input  4  request vector, bit i = requester i; level, held until done or withdrawn
- data0  input  DW  value of requester 0
- data1  input  DW  value of requester 1
- data2  input  DW  value of requester 2
- data3  input  DW  value of requester 3
- sel  output  2  lane select to shifter (index of granted requester)
- cnt  output  DW  value to shifter (latched data of granted requester)
- grant  output  4  one-hot grant, all zero when idle
- busy  output  1  high while a grant is active (HOLD state)
- done  output  4  one-cycle completion pulse, bit i = requester i

Behaviour:
- Interface: one clock, clk; synchronous active-high reset, rst.
- Reset values: sel=0, cnt=0, grant=0, busy=0, done=0, state=IDLE, dwell counter=0, priority pointer ptr=3 (so requester 0 has first priority). Reset mid-grant aborts the grant with no done pulse; reset state is visible the cycle after the rst edge.
- All outputs are registered. No combinational path from req or data to any output.
- FSM states: IDLE, HOLD, RELEASE.
- IDLE:
  - If req==0, stay in IDLE.
  - Otherwise the winner is the first set bit scanning ptr+1, ptr+2, ptr+3, ptr (mod 4).
  - On that edge: sel<=winner, cnt<=data[winner], grant<=onehot(winner), busy<=1, counter<=DWELL-1; go to HOLD.
- HOLD:
  - sel, cnt and grant are frozen. Changes on data inputs are ignored.
  - If req[winner]==0, go to RELEASE as an abort.
  - Else if counter==0, go to RELEASE as a completion.
  - Else decrement the counter.
  - Result: an uninterrupted grant is visible for exactly DWELL cycles.
- Entering RELEASE:
  - grant<=0, busy<=0, cnt<=0; sel keeps its last value.
  - ptr<=winner on both completion and abort.
  - Completion: done[winner]<=1 for the single RELEASE cycle. Abort: done stays 0.
- RELEASE: always goes to IDLE next edge; done returns to 0.
- Timing: req sampled at edge N, grant visible cycles N+1..N+DWELL, done in cycle N+DWELL+1. Earliest next grant visible at N+DWELL+3. Back-to-back period is DWELL+2 cycles.
- Requests arriving during HOLD/RELEASE are not lost if held; they are arbitrated at the next IDLE.
- A requester still holding req after its done is arbitrated normally. Because ptr points to it, it has lowest priority.
- DWELL=1: HOLD lasts one cycle, grant visible for one cycle.
- Simultaneous withdrawal of req on the final HOLD cycle (counter==0) is treated as an abort: no done.
- Counter width is 8 bits. DWELL=0 is illegal and not supported.

Test Plan:
- Reset then req=4'b0001, data0=8'hA5, DWELL=4 -> from cycle 2: sel=0, cnt=A5, grant=0001, busy=1 for 4 cycles; then done=0001 for 1 cycle with cnt=0, busy=0.
- req=4'b1111 held constantly, data_i=8'h10+i -> grants in order 0,1,2,3,0, each 4 cycles long, with a 2-cycle gap (RELEASE+IDLE) between grants; each done bit pulses once per grant.
- Grant to requester 2 active; data2 changed from 8'h33 to 8'hCC mid-HOLD -> cnt remains 33 for the full dwell.
- Grant to requester 1; req[1] dropped in the 2nd HOLD cycle -> next cycle grant=0, busy=0, done=0000; the next arbitration starts scanning from requester 2.
- Assert rst during HOLD with req=4'b0100 still high -> all outputs 0 the next cycle, no done; after rst releases, requester 2 is re-granted.
- DWELL=1, req=4'b1000, data3=8'hFF -> grant=1000 and cnt=FF for exactly 1 cycle, then done=1000 for 1 cycle.

Source files
------------

// File: rtl/shifter_scan_ctrl_if.sv
// Requester/shifter-side bundle for shifter_scan_ctrl: request vector and
// per-requester data in, lane select / value / grant status out.
interface shifter_scan_ctrl_if #(
   parameter int unsigned DW = 8
);
   logic [3:0]    req;
   logic [DW-1:0] data0;
   logic [DW-1:0] data1;
   logic [DW-1:0] data2;
   logic [DW-1:0] data3;
   logic [1:0]    sel;
   logic [DW-1:0] cnt;
   logic [3:0]    grant;
   logic          busy;
   logic [3:0]    done;

   modport master (
      output req, data0, data1, data2, data3,
      input  sel, cnt, grant, busy, done
   );

   modport slave (
      input  req, data0, data1, data2, data3,
      output sel, cnt, grant, busy, done
   );
endinterface

// File: rtl/shifter_scan_ctrl.sv
// Round-robin scheduler sharing the 4-lane output shifter among four
// requesters; each grant holds the path for DWELL cycles then pulses done.
module shifter_scan_ctrl #(
   parameter int unsigned DWELL = 4,
   parameter int unsigned DW    = 8
) (
   input  logic                clk,
   input  logic                rst,
   shifter_scan_ctrl_if.slave  bus
);

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] HOLD    = 2'd1;
   localparam logic [1:0] RELEASE = 2'd2;

   localparam logic [7:0] DWELL_M1 = 8'(DWELL - 1);

   logic [1:0]    state_q, state_d;
   logic [7:0]    ctr_q, ctr_d;
   logic [1:0]    ptr_q, ptr_d;
   logic [1:0]    sel_q, sel_d;
   logic [DW-1:0] cnt_q, cnt_d;
   logic [3:0]    grant_q, grant_d;
   logic          busy_q, busy_d;
   logic [3:0]    done_q, done_d;

   logic [DW-1:0] data_arr [4];
   logic [1:0]    win;
   logic [1:0]    idx;
   logic          found;

   always_comb begin
      data_arr[0] = bus.data0;
      data_arr[1] = bus.data1;
      data_arr[2] = bus.data2;
      data_arr[3] = bus.data3;
   end

   // Scan ptr+1 .. ptr+4 (mod 4) so the last winner has lowest priority.
   always_comb begin
      found = 1'b0;
      win   = ptr_q;
      idx   = '0;
      for (int unsigned k = 1; k <= 4; k++) begin
         idx = ptr_q + 2'(k);
         if (!found && bus.req[idx]) begin
            found = 1'b1;
            win   = idx;
         end
      end
   end

   // sel_q doubles as the winner index while in HOLD.
   always_comb begin
      state_d = state_q;
      ctr_d   = ctr_q;
      ptr_d   = ptr_q;
      sel_d   = sel_q;
      cnt_d   = cnt_q;
      grant_d = grant_q;
      busy_d  = busy_q;
      done_d  = '0;
      case (state_q)
         IDLE: begin
            if (found) begin
               sel_d   = win;
               cnt_d   = data_arr[win];
               grant_d = 4'b0001 << win;
               busy_d  = 1'b1;
               ctr_d   = DWELL_M1;
               state_d = HOLD;
            end
         end
         HOLD: begin
            if (!bus.req[sel_q] || ctr_q == '0) begin
               grant_d = '0;
               busy_d  = 1'b0;
               cnt_d   = '0;
               ptr_d   = sel_q;
               state_d = RELEASE;
               if (bus.req[sel_q]) begin
                  done_d = 4'b0001 << sel_q;
               end
            end else begin
               ctr_d = ctr_q - 8'd1;
            end
         end
         RELEASE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         ctr_q   <= '0;
         ptr_q   <= 2'd3;
         sel_q   <= '0;
         cnt_q   <= '0;
         grant_q <= '0;
         busy_q  <= 1'b0;
         done_q  <= '0;
      end else begin
         state_q <= state_d;
         ctr_q   <= ctr_d;
         ptr_q   <= ptr_d;
         sel_q   <= sel_d;
         cnt_q   <= cnt_d;
         grant_q <= grant_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign bus.sel   = sel_q;
   assign bus.cnt   = cnt_q;
   assign bus.grant = grant_q;
   assign bus.busy  = busy_q;
   assign bus.done  = done_q;

endmodule
